// File: rtl/instr_entry.sv
// Instruction entry: three presses (op, ra, rb) build an instruction offered on a valid/ready port.
// Optional button debounce is enabled by defining INSTR_ENTRY_DEBOUNCE_EN.
module instr_entry #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       setButton,
    input  logic [3:0] inputs,
    input  logic       instr_ready,
    output logic       instr_valid,
    output logic [3:0] instr_op,
    output logic [3:0] instr_ra,
    output logic [3:0] instr_rb,
    output logic [1:0] phase,
    output logic [3:0] live_value,
    output logic       err
);

    typedef enum logic [1:0] {
        S_OP    = 2'd0,
        S_RA    = 2'd1,
        S_RB    = 2'd2,
        S_ISSUE = 2'd3
    } state_t;

    state_t     state;
    logic       btn_s1;
    logic       btn_s2;
    logic [3:0] in_s1;
    logic [3:0] in_s2;
    logic [1:0] settle;
    logic       settled;
    logic       deb_level;
    logic       prev_level;
    logic       press;

    // Two-flop synchronizers; the button idles released (high) out of reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            btn_s1 <= 1'b1;
            btn_s2 <= 1'b1;
            in_s1  <= 4'd0;
            in_s2  <= 4'd0;
        end else begin
            btn_s1 <= setButton;
            btn_s2 <= btn_s1;
            in_s1  <= inputs;
            in_s2  <= in_s1;
        end
    end

    assign live_value = in_s2;

    // Marks when the synchronizer has flushed its reset value and shows the real pin.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            settle <= 2'b00;
        end else begin
            settle <= {settle[0], 1'b1};
        end
    end

    assign settled = settle[1];

`ifdef INSTR_ENTRY_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt;

    // Accept a level change only after it has held for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            deb_level <= 1'b0;
        end else if (!settled || (btn_s2 == deb_level)) begin
            cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            cnt       <= '0;
            deb_level <= btn_s2;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end
`else
    // Held at "pressed" until the synchronizer has flushed, so a button held
    // through reset release cannot look like a fresh press.
    assign deb_level = settled ? btn_s2 : 1'b0;
`endif

    // Falling edge of the debounced level becomes a one-cycle press pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_level <= 1'b0;
            press      <= 1'b0;
        end else begin
            prev_level <= deb_level;
            press      <= prev_level & ~deb_level;
        end
    end

    // Entry sequencer with registered fields, valid and error pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_OP;
            instr_valid <= 1'b0;
            instr_op    <= 4'd0;
            instr_ra    <= 4'd0;
            instr_rb    <= 4'd0;
            err         <= 1'b0;
        end else begin
            err <= 1'b0;
            unique case (state)
                S_OP: begin
                    if (press) begin
                        instr_op <= live_value;
                        state    <= S_RA;
                    end
                end
                S_RA: begin
                    if (press) begin
                        if (live_value[3]) begin
                            err <= 1'b1;
                        end else begin
                            instr_ra <= live_value;
                            state    <= S_RB;
                        end
                    end
                end
                S_RB: begin
                    if (press) begin
                        if (live_value[3]) begin
                            err <= 1'b1;
                        end else begin
                            instr_rb    <= live_value;
                            instr_valid <= 1'b1;
                            state       <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        state       <= S_OP;
                    end
                end
                default: begin
                    instr_valid <= 1'b0;
                    state       <= S_OP;
                end
            endcase
        end
    end

    assign phase = state;

endmodule

// File: tb/tb_instr_entry.sv
// Directed bench for instr_entry: entry sequence, handshake, rejected IDs,
// debounce filtering, reset behaviour.
module tb_instr_entry;

    logic       clock;
    logic       reset_n;
    logic       setButton;
    logic [3:0] inputs;
    logic       instr_ready;
    logic       instr_valid;
    logic [3:0] instr_op;
    logic [3:0] instr_ra;
    logic [3:0] instr_rb;
    logic [1:0] phase;
    logic [3:0] live_value;
    logic       err;

    int errors = 0;
    int checks = 0;
    int err_cnt = 0;
    int err_base;

    instr_entry #(.DEBOUNCE_CYCLES(4)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .setButton   (setButton),
        .inputs      (inputs),
        .instr_ready (instr_ready),
        .instr_valid (instr_valid),
        .instr_op    (instr_op),
        .instr_ra    (instr_ra),
        .instr_rb    (instr_rb),
        .phase       (phase),
        .live_value  (live_value),
        .err         (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count cycles in which err is high, sampled mid-cycle.
    always @(negedge clock) begin
        if (err === 1'b1) err_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press_btn(input logic [3:0] v);
        inputs = v;
        tick(4);
        setButton = 1'b0;
        tick(8);
        setButton = 1'b1;
        tick(8);
    endtask

    initial begin
        reset_n     = 1'b0;
        setButton   = 1'b1;
        inputs      = 4'h0;
        instr_ready = 1'b0;
        #3;
        check("rst_phase", 8'(phase), 8'h0);
        check("rst_valid", 8'(instr_valid), 8'h0);
        check("rst_op", 8'(instr_op), 8'h0);
        check("rst_err", 8'(err), 8'h0);
        check("rst_live", 8'(live_value), 8'h0);
        tick(2);
        reset_n = 1'b1;
        tick(12);
        check("idle_phase", 8'(phase), 8'h0);

        inputs = 4'h1;
        tick(4);
        check("live_sync", 8'(live_value), 8'h1);
        press_btn(4'h1);
        check("op_phase", 8'(phase), 8'h1);
        check("op_val", 8'(instr_op), 8'h1);
        press_btn(4'h2);
        check("ra_phase", 8'(phase), 8'h2);
        check("ra_val", 8'(instr_ra), 8'h2);
        press_btn(4'h5);
        check("issue_phase", 8'(phase), 8'h3);
        check("issue_valid", 8'(instr_valid), 8'h1);
        check("issue_op", 8'(instr_op), 8'h1);
        check("issue_ra", 8'(instr_ra), 8'h2);
        check("issue_rb", 8'(instr_rb), 8'h5);

        tick(10);
        check("hold_valid", 8'(instr_valid), 8'h1);
        check("hold_phase", 8'(phase), 8'h3);
        check("hold_rb", 8'(instr_rb), 8'h5);
        instr_ready = 1'b1;
        tick(1);
        instr_ready = 1'b0;
        check("hs_valid", 8'(instr_valid), 8'h0);
        check("hs_phase", 8'(phase), 8'h0);
        check("hs_op_kept", 8'(instr_op), 8'h1);

        instr_ready = 1'b1;
        tick(3);
        instr_ready = 1'b0;
        check("ready_idle_phase", 8'(phase), 8'h0);
        check("ready_idle_valid", 8'(instr_valid), 8'h0);

        press_btn(4'h3);
        check("op2_phase", 8'(phase), 8'h1);
        err_base = err_cnt;
        press_btn(4'h9);
        check("bad_err_cycles", 8'(err_cnt - err_base), 8'h1);
        check("bad_phase", 8'(phase), 8'h1);
        check("bad_ra_kept", 8'(instr_ra), 8'h2);
        press_btn(4'h4);
        check("ra2_val", 8'(instr_ra), 8'h4);
        err_base = err_cnt;
        press_btn(4'hF);
        check("bad_rb_err", 8'(err_cnt - err_base), 8'h1);
        check("bad_rb_phase", 8'(phase), 8'h2);
        press_btn(4'h7);
        check("issue2_valid", 8'(instr_valid), 8'h1);
        check("issue2_rb", 8'(instr_rb), 8'h7);
        press_btn(4'hA);
        check("issue_press_phase", 8'(phase), 8'h3);
        check("issue_press_op", 8'(instr_op), 8'h3);
        instr_ready = 1'b1;
        tick(1);
        instr_ready = 1'b0;
        check("hs2_phase", 8'(phase), 8'h0);

`ifdef INSTR_ENTRY_DEBOUNCE_EN
        inputs = 4'h6;
        tick(4);
        setButton = 1'b0;
        tick(3);
        setButton = 1'b1;
        tick(1);
        setButton = 1'b0;
        tick(3);
        setButton = 1'b1;
        tick(10);
        check("bounce_no_press", 8'(phase), 8'h0);
        setButton = 1'b0;
        tick(6);
        setButton = 1'b1;
        tick(10);
        check("deb_one_phase", 8'(phase), 8'h1);
        check("deb_one_op", 8'(instr_op), 8'h6);
`else
        press_btn(4'h6);
        check("op3_phase", 8'(phase), 8'h1);
        check("op3_val", 8'(instr_op), 8'h6);
`endif

        press_btn(4'h1);
        check("pre_rst_phase", 8'(phase), 8'h2);
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_phase", 8'(phase), 8'h0);
        check("arst_valid", 8'(instr_valid), 8'h0);
        check("arst_op", 8'(instr_op), 8'h0);
        check("arst_ra", 8'(instr_ra), 8'h0);
        check("arst_rb", 8'(instr_rb), 8'h0);
        check("arst_err", 8'(err), 8'h0);
        check("arst_live", 8'(live_value), 8'h0);

        setButton = 1'b0;
        inputs = 4'hC;
        tick(2);
        reset_n = 1'b1;
        tick(12);
        check("held_no_press", 8'(phase), 8'h0);
        setButton = 1'b1;
        tick(10);
        check("release_no_press", 8'(phase), 8'h0);
        press_btn(4'hC);
        check("held_then_press_phase", 8'(phase), 8'h1);
        check("held_then_press_op", 8'(instr_op), 8'hC);
        tick(5);
        check("held_single_press", 8'(phase), 8'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_entry.md
INSTR_ENTRY -- requirements
Module: instr_entry

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250000, number of consecutive stable clock cycles required to accept a button level change.
REQ-002 SHALL have port clock  input  1  sole clock, all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port setButton  input  1  active-low pushbutton, asynchronous to clock.
REQ-005 SHALL have port inputs  input  4  switch value, asynchronous to clock.
REQ-006 SHALL have port instr_ready  input  1  consumer accepts the instruction.
REQ-007 SHALL have port instr_valid  output  1  instruction fields complete and stable.
REQ-008 SHALL have ports instr_op, instr_ra, instr_rb  output  4 each  captured opcode, register A ID, register B ID.
REQ-009 SHALL have port phase  output  2  current state encoding, for the display driver.
REQ-010 SHALL have port live_value  output  4  synchronized switch value, for the display driver.
REQ-011 SHALL have port err  output  1  one-cycle pulse on a rejected register-ID entry.

Function
REQ-012 SHALL pass setButton and inputs through two-flop synchronizers; live_value is the second synchronizer stage.
REQ-013 SHALL define a press as a 1->0 transition of the debounced button level, registered as a single-cycle internal pulse.
REQ-014 SHALL use states S_OP=0, S_RA=1, S_RB=2, S_ISSUE=3; phase reflects the state register directly.
REQ-015 In S_OP, a press SHALL capture live_value into instr_op and move to S_RA on the same edge.
REQ-016 In S_RA or S_RB, a press with live_value[3]=0 SHALL capture into instr_ra or instr_rb respectively and advance (S_RA->S_RB, S_RB->S_ISSUE).
REQ-017 In S_RA or S_RB, a press with live_value[3]=1 (register ID >7) SHALL leave the field and state unchanged and pulse err high for exactly one cycle.
REQ-018 instr_valid SHALL be registered, high exactly while in S_ISSUE, first high the cycle after the S_RB capture edge.
REQ-019 In S_ISSUE, instr_valid&&instr_ready on a rising edge SHALL complete the handshake: next cycle valid=0, state=S_OP.
REQ-020 instr_op/ra/rb SHALL be stable while instr_valid=1 and SHALL retain their values after the handshake until overwritten.
REQ-021 Presses in S_ISSUE SHALL be discarded, including a press coincident with the handshake.
REQ-022 instr_ready while instr_valid=0 SHALL have no effect.
REQ-023 Latency: debounced falling edge at cycle N -> press pulse N+1 -> field/state updated at end of N+1.

Reset
REQ-024 Asserting reset_n low SHALL immediately force state=S_OP, instr_valid=0, err=0, instr_op/ra/rb=0, debounce counter=0, input synchronizers=0.
REQ-025 Reset SHALL force button synchronizers to 1 and the debounced level to 0 (pressed), so a button held through reset release never generates a press.
REQ-026 Reset mid-entry or mid-handshake SHALL discard partial fields; no instruction is issued.

Configuration
REQ-027 With INSTR_ENTRY_DEBOUNCE_EN defined, the debounced level SHALL change only after the synchronized button differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce resets the counter to 0.
REQ-028 Without INSTR_ENTRY_DEBOUNCE_EN, the debounced level SHALL equal the second synchronizer stage, DEBOUNCE_CYCLES is unused, and no counter is instantiated.

Verification
REQ-029 DEBOUNCE_CYCLES=4; switches 0x1, press; 0x2, press; 0x5, press -> instr_valid=1 with op=1, ra=2, rb=5, phase=3.
REQ-030 In S_ISSUE, hold instr_ready=0 for 10 cycles -> valid and fields unchanged; ready=1 one cycle -> valid=0 and phase=0 next cycle, op=1 retained.
REQ-031 In S_RA, switches 0x9, press -> err pulses one cycle, phase stays 1, instr_ra unchanged.
REQ-032 Debounce enabled, DEBOUNCE_CYCLES=4: button low 3 cycles, high 1, low 3 -> no press; low 6 cycles -> exactly one press.
REQ-033 Button held low across reset release, then released and pressed again -> exactly one press, captured into instr_op.
REQ-034 Assert reset_n in S_RB -> all outputs 0 and phase=0 immediately, with no clock edge required.
